// File: rtl/prompt_sequencer.sv
// prompt_sequencer
//   Frame-synchronous scheduler for the on-screen text-prompt sprite
//   controllers. Show/clear requests from game logic are held pending and
//   applied only on the frame boundary (last pixel of the frame, inside
//   vertical blanking). A prompt therefore never appears or vanishes mid-frame.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   hCount, vCount    VGA raster position (may hold for several clk cycles)
//   show_req          1-clk pulse: request display of show_id
//   show_id           prompt index (ignored when >= N_PROMPTS)
//   show_frames       display duration in frames, 0 = indefinite
//   blink_en          blink the prompt with a half-period of BLINK_FRAMES
//   clear_req         1-clk pulse: remove displayed or pending prompt
//   prompt_en         registered one-hot enable to the sprite controllers
//   active_id         index of the prompt being shown, 0 when idle
//   busy              showing, or a request is pending
//   done              1-clk pulse when a timed display expires
module prompt_sequencer #(
  parameter int N_PROMPTS    = 4,
  parameter int ID_W         = 2,
  parameter int CNT_W        = 10,
  parameter int H_TOTAL      = 800,
  parameter int V_TOTAL      = 525,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [9:0]           hCount,
  input  logic [9:0]           vCount,
  input  logic                 show_req,
  input  logic [ID_W-1:0]      show_id,
  input  logic [CNT_W-1:0]     show_frames,
  input  logic                 blink_en,
  input  logic                 clear_req,
  output logic [N_PROMPTS-1:0] prompt_en,
  output logic [ID_W-1:0]      active_id,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic {IDLE, SHOW} state_t;

  localparam int            BW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);

  state_t                 state_q, state_d;
  logic                   at_end_q, at_end_d;
  logic                   frame_tick;
  logic                   show_ok;

  logic                   pend_valid_q, pend_valid_d;
  logic                   pend_clear_q, pend_clear_d;
  logic                   pend_blink_q, pend_blink_d;
  logic [ID_W-1:0]        pend_id_q, pend_id_d;
  logic [CNT_W-1:0]       pend_frames_q, pend_frames_d;

  logic [ID_W-1:0]        active_id_q, active_id_d;
  logic [CNT_W-1:0]       frames_left_q, frames_left_d;
  logic                   blink_q, blink_d;
  logic [BW-1:0]          blink_cnt_q, blink_cnt_d;
  logic                   visible_q, visible_d;
  logic [N_PROMPTS-1:0]   prompt_en_q, prompt_en_d;
  logic                   done_q, done_d;

  // Last pixel of the frame; edge-detected so a held raster count yields
  // exactly one tick.
  assign at_end_d   = (hCount == 10'(H_TOTAL - 1)) && (vCount == 10'(V_TOTAL - 1));
  assign frame_tick = at_end_d && !at_end_q;

  // Extra top bit so N_PROMPTS == 2**ID_W still compares correctly.
  assign show_ok = ({1'b0, show_id} < (ID_W + 1)'(N_PROMPTS));

  // Pending-request capture. The tick consumes what was pending before this
  // cycle; a request arriving on the tick cycle survives for the next tick.
  always_comb begin
    pend_valid_d  = pend_valid_q;
    pend_clear_d  = pend_clear_q;
    pend_blink_d  = pend_blink_q;
    pend_id_d     = pend_id_q;
    pend_frames_d = pend_frames_q;
    if (frame_tick) begin
      pend_valid_d = 1'b0;
      pend_clear_d = 1'b0;
    end
    if (clear_req) begin
      pend_clear_d = 1'b1;
      pend_valid_d = 1'b0;
    end else if (show_req && show_ok) begin
      pend_valid_d  = 1'b1;
      pend_clear_d  = 1'b0;
      pend_id_d     = show_id;
      pend_frames_d = show_frames;
      pend_blink_d  = blink_en;
    end
  end

  // Display FSM: every transition happens on frame_tick only.
  always_comb begin
    state_d       = state_q;
    active_id_d   = active_id_q;
    frames_left_d = frames_left_q;
    blink_d       = blink_q;
    blink_cnt_d   = blink_cnt_q;
    visible_d     = visible_q;
    done_d        = 1'b0;
    if (frame_tick) begin
      if (pend_clear_q) begin
        state_d       = IDLE;
        active_id_d   = '0;
        frames_left_d = '0;
        blink_d       = 1'b0;
        blink_cnt_d   = '0;
        visible_d     = 1'b0;
      end else if (pend_valid_q) begin
        state_d       = SHOW;
        active_id_d   = pend_id_q;
        frames_left_d = pend_frames_q;
        blink_d       = pend_blink_q;
        blink_cnt_d   = '0;
        visible_d     = 1'b1;
      end else if (state_q == SHOW) begin
        if (frames_left_q == CNT_W'(1)) begin
          state_d       = IDLE;
          active_id_d   = '0;
          frames_left_d = '0;
          blink_d       = 1'b0;
          blink_cnt_d   = '0;
          visible_d     = 1'b0;
          done_d        = 1'b1;
        end else begin
          // frames_left == 0 means indefinite: leave it alone.
          if (frames_left_q != '0)
            frames_left_d = frames_left_q - CNT_W'(1);
          if (blink_q) begin
            if (blink_cnt_q == BLINK_MAX) begin
              blink_cnt_d = '0;
              visible_d   = !visible_q;
            end else begin
              blink_cnt_d = blink_cnt_q + BW'(1);
            end
          end
        end
      end
    end
  end

  // Enables follow the next state so they change on the edge that consumes
  // the tick (pixel 0,0 of the new frame).
  for (genvar i = 0; i < N_PROMPTS; i++) begin : g_en
    assign prompt_en_d[i] = (state_d == SHOW) && visible_d && (active_id_d == ID_W'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      at_end_q      <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_clear_q  <= 1'b0;
      pend_blink_q  <= 1'b0;
      pend_id_q     <= '0;
      pend_frames_q <= '0;
      active_id_q   <= '0;
      frames_left_q <= '0;
      blink_q       <= 1'b0;
      blink_cnt_q   <= '0;
      visible_q     <= 1'b0;
      prompt_en_q   <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      at_end_q      <= at_end_d;
      pend_valid_q  <= pend_valid_d;
      pend_clear_q  <= pend_clear_d;
      pend_blink_q  <= pend_blink_d;
      pend_id_q     <= pend_id_d;
      pend_frames_q <= pend_frames_d;
      active_id_q   <= active_id_d;
      frames_left_q <= frames_left_d;
      blink_q       <= blink_d;
      blink_cnt_q   <= blink_cnt_d;
      visible_q     <= visible_d;
      prompt_en_q   <= prompt_en_d;
      done_q        <= done_d;
    end
  end

  assign prompt_en = prompt_en_q;
  assign active_id = active_id_q;
  assign done      = done_q;
  assign busy      = (state_q == SHOW) || pend_valid_q || pend_clear_q;

endmodule
